// File: rtl/dds_pkg.sv
// dds_pkg: shared widths and constants for the dds_nco numerically controlled
// oscillator. The LFSR seed, taps and step function exist only when the
// DDS_NCO_DITHER_EN macro is defined.
package dds_pkg;

    localparam int PHASE_W   = 32;
    localparam int ADDR_W    = 8;
    localparam int SAMPLE_W  = 8;
    localparam int QTR_DEPTH = 64;
    localparam int QTR_IDX_W = $clog2(QTR_DEPTH);
    localparam int LUT_W     = 7;

`ifdef DDS_NCO_DITHER_EN
    // Galois form of x^16 + x^14 + x^13 + x^11 + 1, shifting right.
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
    endfunction
`endif

endpackage

// File: rtl/dds_sin_lut.sv
// dds_sin_lut: synchronous 64 x 7 quarter-wave sine ROM (pipeline stage S2).
// Entry k holds round(127*sin(2*pi*(k+0.5)/256)).
// Ports:
//   clk   - system clock
//   rst_n - asynchronous active-low reset (clears the read register)
//   idx   - folded quarter-wave index, 0..63
//   mag   - registered unsigned magnitude, 2..127
module dds_sin_lut
    import dds_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [QTR_IDX_W-1:0] idx,
    output logic [LUT_W-1:0]     mag
);

    localparam logic [LUT_W-1:0] QTAB [QTR_DEPTH] = '{
          7'd2,   7'd5,   7'd8,  7'd11,  7'd14,  7'd17,  7'd20,  7'd23,
         7'd26,  7'd29,  7'd32,  7'd35,  7'd38,  7'd41,  7'd44,  7'd47,
         7'd50,  7'd53,  7'd56,  7'd58,  7'd61,  7'd64,  7'd67,  7'd69,
         7'd72,  7'd74,  7'd77,  7'd79,  7'd82,  7'd84,  7'd86,  7'd89,
         7'd91,  7'd93,  7'd95,  7'd97,  7'd99, 7'd101, 7'd103, 7'd105,
        7'd106, 7'd108, 7'd110, 7'd111, 7'd113, 7'd114, 7'd115, 7'd117,
        7'd118, 7'd119, 7'd120, 7'd121, 7'd122, 7'd123, 7'd124, 7'd124,
        7'd125, 7'd125, 7'd126, 7'd126, 7'd127, 7'd127, 7'd127, 7'd127
    };

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) mag <= '0;
        else        mag <= QTAB[idx];
    end

endmodule

// File: rtl/dds_nco.sv
// dds_nco: numerically controlled oscillator producing signed 8-bit sine
// samples. A 32-bit phase accumulator advances once per sample tick; the top
// address bits index a folded quarter-wave table through a 3-stage pipeline
// (S1 fold, S2 ROM read, S3 sign + output register).
// Optional feature: define DDS_NCO_DITHER_EN to add LFSR phase dither.
// Ports:
//   clk          - system clock
//   rst_n        - asynchronous active-low reset
//   en           - run enable; divider and accumulator hold while low
//   freq_in      - frequency tuning word, loaded into the shadow register
//   freq_we      - one-cycle write strobe for freq_in
//   freq_ack     - one-cycle pulse the cycle after the shadow word goes active
//   phase_ofs    - static phase offset added to acc[31:16]
//   sync         - accumulator clears at the next tick
//   sample       - signed sine sample, -127..127, held between strobes
//   sample_valid - one-cycle strobe qualifying sample
module dds_nco
    import dds_pkg::*;
#(
    parameter int DIV = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic [31:0]         freq_in,
    input  logic                freq_we,
    output logic                freq_ack,
    input  logic [15:0]         phase_ofs,
    input  logic                sync,
    output logic [SAMPLE_W-1:0] sample,
    output logic                sample_valid
);

    logic [15:0]          div_cnt;
    logic                 tick;
    logic [PHASE_W-1:0]   acc;
    logic [PHASE_W-1:0]   f_active;
    logic [PHASE_W-1:0]   f_shadow;
    logic                 pending;
    logic [ADDR_W-1:0]    addr;

    logic                 s1_valid;
    logic                 s1_neg;
    logic [QTR_IDX_W-1:0] s1_idx;
    logic                 s2_valid;
    logic                 s2_neg;
    logic [LUT_W-1:0]     s2_mag;
    logic [SAMPLE_W-1:0]  mag_ext;

    assign tick = en && (div_cnt == 16'(DIV - 1));

`ifdef DDS_NCO_DITHER_EN
    logic [15:0] lfsr;

    // Dither is confined to the bits below the table address, so it moves the
    // address by at most one LUT step.
    assign addr = ADDR_W'(16'(acc[PHASE_W-1 -: 16] + phase_ofs + {8'h00, lfsr[7:0]}) >> 8);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    lfsr <= LFSR_SEED;
        else if (tick) lfsr <= lfsr_next(lfsr);
    end
`else
    assign addr = ADDR_W'(16'(acc[PHASE_W-1 -: 16] + phase_ofs) >> 8);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt  <= '0;
            acc      <= '0;
            f_active <= '0;
            f_shadow <= '0;
            pending  <= 1'b0;
            freq_ack <= 1'b0;
        end else begin
            if (en) div_cnt <= tick ? '0 : div_cnt + 16'd1;

            freq_ack <= tick && pending;

            // The increment always uses the word active before this tick, so
            // a newly applied word only affects the following increment.
            if (tick) begin
                acc <= sync ? '0 : acc + f_active;
                if (pending) f_active <= f_shadow;
            end

            // A write coinciding with an applying tick re-arms pending with
            // the new word while the old shadow goes active.
            if (freq_we) begin
                f_shadow <= freq_in;
                pending  <= 1'b1;
            end else if (tick) begin
                pending  <= 1'b0;
            end
        end
    end

    // S1: quadrant sign and folded index (63-i is the bitwise complement).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_neg   <= 1'b0;
            s1_idx   <= '0;
        end else begin
            s1_valid <= tick;
            s1_neg   <= addr[ADDR_W-1];
            s1_idx   <= addr[ADDR_W-2] ? ~addr[QTR_IDX_W-1:0] : addr[QTR_IDX_W-1:0];
        end
    end

    // S2: ROM read, with valid and sign carried alongside.
    dds_sin_lut u_lut (
        .clk   (clk),
        .rst_n (rst_n),
        .idx   (s1_idx),
        .mag   (s2_mag)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            s2_neg   <= 1'b0;
        end else begin
            s2_valid <= s1_valid;
            s2_neg   <= s1_neg;
        end
    end

    // S3: apply sign; magnitude is at most 127, so negation cannot overflow.
    assign mag_ext = {{(SAMPLE_W - LUT_W){1'b0}}, s2_mag};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sample       <= '0;
            sample_valid <= 1'b0;
        end else begin
            sample_valid <= s2_valid;
            if (s2_valid) sample <= s2_neg ? -mag_ext : mag_ext;
        end
    end

endmodule
